// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Command/status bundle between a requester and the PS/2 host transmitter.
//   tx_data       [7:0] command byte to send to the keyboard
//   tx_valid            request; accepted together with tx_ready
//   tx_ready            transmitter idle and able to accept a byte
//   busy                transfer in progress (receive side must ignore bus)
//   done                one-cycle pulse: byte sent and ACKed
//   ack_error           one-cycle pulse: device did not ACK
//   timeout_error       one-cycle pulse: transfer did not finish in time
// master = requester, slave = ps2_host_tx.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_error;
    logic       timeout_error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_error, timeout_error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_error, timeout_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out 8 data bits LSB first + odd parity + stop on device clock
// falling edges, then checks the device ACK.
//   clock          system clock
//   reset          asynchronous, active-low
//   bus            ps2_host_tx_if.slave (tx_data/tx_valid/tx_ready, status)
//   ps2_clk_in     raw PS/2 clock line (asynchronous)
//   ps2_data_in    raw PS/2 data line (asynchronous)
//   ps2_clk_oe     1 = pull PS/2 clock low
//   ps2_data_oe    1 = pull PS/2 data low
// Parameters: INHIBIT_CYCLES (clock hold-low time), TIMEOUT_CYCLES (limit
// from request-to-send to end of transfer).
// Optional macro PS2_HOST_TX_RETRY_EN: the first ACK or timeout failure of a
// byte silently restarts from the inhibit phase; the second one is reported.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic         clock,
    input  logic         reset,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] ILAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    // Data-line pull is asserted in the last inhibit cycle; with a one-cycle
    // inhibit that cycle is the first one.
    localparam logic INH_DATA0 = (INHIBIT_CYCLES == 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_RTS     = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]    state, state_d;
    logic [IW-1:0] icnt, icnt_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [3:0]    bcnt, bcnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          par_q, par_d;
    logic          clk_oe_d, data_oe_d;
    logic          done_d, ack_err_d, to_err_d;
    logic          fail, fail_to;
    logic          clk_s1, clk_s2, clk_s3, data_s1, data_s2;
    logic          fall;
    logic [9:0]    frame;
`ifdef PS2_HOST_TX_RETRY_EN
    logic          retried, retried_d;
`endif

    assign fall  = clk_s3 & ~clk_s2;
    assign frame = {1'b1, par_q, byte_q};

    always_comb begin
        state_d   = state;
        icnt_d    = icnt;
        tcnt_d    = tcnt;
        bcnt_d    = bcnt;
        byte_d    = byte_q;
        par_d     = par_q;
        clk_oe_d  = ps2_clk_oe;
        data_oe_d = ps2_data_oe;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        to_err_d  = 1'b0;
        fail      = 1'b0;
        fail_to   = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retried_d = retried;
`endif
        case (state)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (bus.tx_valid && bus.tx_ready) begin
                    byte_d    = bus.tx_data;
                    par_d     = ~^bus.tx_data;
                    state_d   = S_INHIBIT;
                    icnt_d    = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = INH_DATA0;
`ifdef PS2_HOST_TX_RETRY_EN
                    retried_d = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (icnt == ILAST) begin
                    state_d   = S_RTS;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    tcnt_d    = '0;
                end else begin
                    icnt_d    = icnt + 1'b1;
                    data_oe_d = (icnt_d == ILAST);
                end
            end
            S_RTS: begin
                state_d = S_SEND;
                bcnt_d  = '0;
            end
            S_SEND: begin
                if (fall) begin
                    data_oe_d = ~frame[bcnt];
                    if (bcnt == 4'd9) state_d = S_ACK;
                    else              bcnt_d  = bcnt + 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (!data_s2) state_d = S_RELEASE;
                    else          fail    = 1'b1;
                end
            end
            S_RELEASE: begin
                if (clk_s2 && data_s2) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

        // Timeout is evaluated after the state actions so it wins over any
        // edge or release event seen in the same cycle.
        if (state == S_RTS || state == S_SEND || state == S_ACK || state == S_RELEASE) begin
            if (tcnt == TLAST) begin
                fail    = 1'b1;
                fail_to = 1'b1;
            end else begin
                tcnt_d = tcnt + 1'b1;
            end
        end

        if (fail) begin
            done_d    = 1'b0;
            state_d   = S_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            if (!retried) begin
                retried_d = 1'b1;
                state_d   = S_INHIBIT;
                icnt_d    = '0;
                clk_oe_d  = 1'b1;
                data_oe_d = INH_DATA0;
            end else begin
                to_err_d  = fail_to;
                ack_err_d = ~fail_to;
            end
`else
            to_err_d  = fail_to;
            ack_err_d = ~fail_to;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            icnt              <= '0;
            tcnt              <= '0;
            bcnt              <= '0;
            byte_q            <= '0;
            par_q             <= 1'b0;
            ps2_clk_oe        <= 1'b0;
            ps2_data_oe       <= 1'b0;
            bus.tx_ready      <= 1'b1;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.ack_error     <= 1'b0;
            bus.timeout_error <= 1'b0;
            clk_s1            <= 1'b1;
            clk_s2            <= 1'b1;
            clk_s3            <= 1'b1;
            data_s1           <= 1'b1;
            data_s2           <= 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
            retried           <= 1'b0;
`endif
        end else begin
            state             <= state_d;
            icnt              <= icnt_d;
            tcnt              <= tcnt_d;
            bcnt              <= bcnt_d;
            byte_q            <= byte_d;
            par_q             <= par_d;
            ps2_clk_oe        <= clk_oe_d;
            ps2_data_oe       <= data_oe_d;
            bus.tx_ready      <= (state_d == S_IDLE);
            bus.busy          <= (state_d != S_IDLE);
            bus.done          <= done_d;
            bus.ack_error     <= ack_err_d;
            bus.timeout_error <= to_err_d;
            clk_s1            <= ps2_clk_in;
            clk_s2            <= clk_s1;
            clk_s3            <= clk_s2;
            data_s1           <= ps2_data_in;
            data_s2           <= data_s1;
`ifdef PS2_HOST_TX_RETRY_EN
            retried           <= retried_d;
`endif
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 500;
    localparam logic [2:0] F_DONE = 3'b100;
    localparam logic [2:0] F_ACK  = 3'b010;
    localparam logic [2:0] F_TO   = 3'b001;
`ifdef PS2_HOST_TX_RETRY_EN
    // A bad ACK is retried; the device model answers only once, so the retry
    // ends in a timeout.
    localparam logic [2:0] ACKBAD_FLAGS = F_TO;
    localparam int         FAIL_INH     = 2;
`else
    localparam logic [2:0] ACKBAD_FLAGS = F_ACK;
    localparam int         FAIL_INH     = 1;
`endif

    typedef struct {
        logic [7:0] b;
        bit         ack_good;
        bit         spam;
        logic [2:0] exp_flags;
        int         exp_inh;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    ps2_host_tx_if bus();

    always #5 clock = ~clock;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int checks = 0;
    int failures = 0;

    // Bus monitor, sampled on the falling system-clock edge.
    int cyc = 0, n_done = 0, n_ack = 0, n_to = 0, n_inh = 0;
    int inh_len = 0, data_first = 0, rts_cyc = 0, to_cyc = 0;
    logic       clk_oe_prev = 1'b0;
    logic [2:0] last_flags = '0;
    logic [1:0] last_oe = '0;
    logic       ready_after = 1'b0, busy_after = 1'b1, pend_after = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (pend_after) begin
            ready_after = bus.tx_ready;
            busy_after  = bus.busy;
            pend_after  = 1'b0;
        end
        if (bus.done === 1'b1) n_done++;
        if (bus.ack_error === 1'b1) n_ack++;
        if (bus.timeout_error === 1'b1) begin n_to++; to_cyc = cyc; end
        if (bus.done === 1'b1 || bus.ack_error === 1'b1 || bus.timeout_error === 1'b1) begin
            last_flags = {bus.done, bus.ack_error, bus.timeout_error};
            last_oe    = {ps2_clk_oe, ps2_data_oe};
            pend_after = 1'b1;
        end
        if (ps2_clk_oe === 1'b1) begin
            if (clk_oe_prev !== 1'b1) begin n_inh++; inh_len = 0; data_first = 0; end
            inh_len++;
            if (ps2_data_oe === 1'b1 && data_first == 0) data_first = inh_len;
        end else if (clk_oe_prev === 1'b1) begin
            rts_cyc = cyc;
        end
        clk_oe_prev = ps2_clk_oe;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference frame: data LSB first, odd parity, stop = 1.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones = 0;
        logic [9:0] f;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            if (b[i]) ones++;
        end
        f[8] = ((ones % 2) == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    // One device-side attempt: wait for request-to-send, give npulse clock
    // pulses sampling data on each rising edge, and (npulse > 10) an ACK pulse.
    task automatic dev_attempt(input bit ack_good, input int npulse,
                               output logic [9:0] bits, output logic rts_ok);
        int t = 0;
        bits   = '0;
        rts_ok = 1'b0;
        while (ps2_clk_oe !== 1'b1 && t < 2*TMO) begin tick(1); t++; end
        while (ps2_clk_oe !== 1'b0 && t < 2*TMO) begin tick(1); t++; end
        check("rts_wait", 32'(t < 2*TMO), 1);
        if (t >= 2*TMO) return;
        rts_ok = (ps2_data_in === 1'b0);
        tick(5);
        for (int i = 0; i < npulse && i < 10; i++) begin
            dev_clk = 1'b0; tick(10);
            dev_clk = 1'b1; bits[i] = ps2_data_in; tick(8);
        end
        if (npulse > 10) begin
            dev_data = ack_good ? 1'b0 : 1'b1; tick(4);
            dev_clk = 1'b0; tick(10);
            dev_clk = 1'b1; tick(2);
            dev_data = 1'b1;
        end
    endtask

    task automatic accept(input logic [7:0] b, input string tag);
        int t = 0;
        while (bus.tx_ready !== 1'b1 && t < 100) begin tick(1); t++; end
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        tick(1);
        check({tag, "_ready_low"}, bus.tx_ready, 0);
        check({tag, "_busy_high"}, bus.busy, 1);
        bus.tx_valid = 1'b0;
        bus.tx_data  = ~b;
    endtask

    task automatic wait_outcome(input int base, input string tag);
        int t = 0;
        while ((n_done + n_ack + n_to) == base && t < 3*TMO) begin tick(1); t++; end
        check({tag, "_outcome_seen"}, 32'(t < 3*TMO), 1);
        tick(3);
    endtask

    task automatic run_txn(input logic [7:0] b, input bit ack_good, input bit spam,
                           input int npulse, input logic [2:0] exp_flags,
                           input int exp_inh, input string tag);
        logic [9:0] bits;
        logic       rts_ok;
        int b_d = n_done, b_a = n_ack, b_t = n_to, b_i = n_inh;
        accept(b, tag);
        bus.tx_valid = spam;
        dev_attempt(ack_good, npulse, bits, rts_ok);
        bus.tx_valid = 1'b0;
        wait_outcome(b_d + b_a + b_t, tag);
        check({tag, "_flags"}, exp_flags, last_flags === exp_flags ? exp_flags : last_flags);
        check({tag, "_start_bit"}, rts_ok, 1);
        if (npulse > 10) check({tag, "_frame"}, bits, model_frame(b));
        check({tag, "_inhibit_len"}, inh_len, INH);
        check({tag, "_data_pull_cycle"}, data_first, INH);
        check({tag, "_inhibit_phases"}, n_inh - b_i, exp_inh);
        check({tag, "_pulse_count"}, (n_done - b_d) + (n_ack - b_a) + (n_to - b_t), 1);
        check({tag, "_lines_released"}, last_oe, 0);
        check({tag, "_ready_after"}, ready_after, 1);
        check({tag, "_busy_after"}, busy_after, 0);
        if (exp_flags == F_TO) check({tag, "_timeout_delay"}, to_cyc - rts_cyc, TMO);
    endtask

    vec_t vecs[5];

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        logic       rts_ok;
        int b_sum;
        logic [7:0] rb;

        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        tick(3);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_pulses", {bus.done, bus.ack_error, bus.timeout_error}, 0);
        reset = 1'b1;
        tick(3);

        vecs[0] = '{8'hED, 1'b1, 1'b0, F_DONE, 1};
        vecs[1] = '{8'h00, 1'b1, 1'b0, F_DONE, 1};
        vecs[2] = '{8'h01, 1'b1, 1'b1, F_DONE, 1};
        vecs[3] = '{8'hF4, 1'b0, 1'b0, ACKBAD_FLAGS, FAIL_INH};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, F_DONE, 1};
        for (int i = 0; i < 5; i++)
            run_txn(vecs[i].b, vecs[i].ack_good, vecs[i].spam, 11,
                    vecs[i].exp_flags, vecs[i].exp_inh, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            run_txn(rb, 1'b1, 1'($urandom_range(0, 1)), 11, F_DONE, 1,
                    $sformatf("rnd%0d_%02h", i, rb));
        end

        // Device never clocks.
        run_txn(8'h55, 1'b1, 1'b0, 0, F_TO, FAIL_INH, "timeout");

        // Reset while bit 4 of 0xED (a 0) is on the bus.
        b_sum = n_done + n_ack + n_to;
        accept(8'hED, "rstmid");
        dev_attempt(1'b1, 5, bits, rts_ok);
        check("rstmid_bits_so_far", bits[4:0], model_frame(8'hED) & 10'h01F);
        check("rstmid_data_pulled", ps2_data_oe, 1);
        reset = 1'b0;
        #1;
        check("rstmid_oe_async", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rstmid_ready_async", bus.tx_ready, 1);
        tick(3);
        reset = 1'b1;
        tick(20);
        check("rstmid_no_pulse", n_done + n_ack + n_to - b_sum, 0);
        run_txn(8'hED, 1'b1, 1'b0, 11, F_DONE, 1, "after_rst");

`ifdef PS2_HOST_TX_RETRY_EN
        begin
            int b_d = n_done, b_a = n_ack, b_i = n_inh;
            accept(8'hED, "retry");
            dev_attempt(1'b0, 11, bits, rts_ok);
            dev_attempt(1'b1, 11, bits, rts_ok);
            wait_outcome(n_done + n_ack + n_to, "retry");
            check("retry_frame", bits, model_frame(8'hED));
            check("retry_done", n_done - b_d, 1);
            check("retry_no_ackerr", n_ack - b_a, 0);
            check("retry_inhibits", n_inh - b_i, 2);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clock cycles PS/2 clock is held low before request-to-send (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, max cycles from RTS release to transfer end (20 ms at 100 MHz).
REQ-003 clock  input  1  system clock; the block's only clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  8  command byte to send to the keyboard.
REQ-006 tx_valid  input  1  request; byte accepted when tx_valid and tx_ready are both high on a rising clock edge.
REQ-007 tx_ready  output  1  high only in IDLE.
REQ-008 ps2_clk_in  input  1  raw PS/2 clock line level (asynchronous).
REQ-009 ps2_data_in  input  1  raw PS/2 data line level (asynchronous).
REQ-010 ps2_clk_oe  output  1  1 = pull PS/2 clock low (open-drain), 0 = release.
REQ-011 ps2_data_oe  output  1  1 = pull PS/2 data low (open-drain), 0 = release.
REQ-012 busy  output  1  high in every state except IDLE; the receive controller ignores the bus while busy.
REQ-013 done  output  1  one-cycle pulse on successful transfer with ACK.
REQ-014 ack_error  output  1  one-cycle pulse when ps2_data is high at the ACK edge.
REQ-015 timeout_error  output  1  one-cycle pulse when TIMEOUT_CYCLES expires.

Function
REQ-016 ps2_clk_in and ps2_data_in pass through 2-flop synchronizers; a falling edge is synchronized clk 1 then 0 on consecutive cycles.
REQ-017 States: IDLE, INHIBIT, RTS, SEND, ACK, RELEASE.
REQ-018 IDLE: both oe=0; on handshake, latch tx_data, compute odd parity (~^tx_data), go INHIBIT.
REQ-019 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe=1 asserted in the last cycle of INHIBIT.
REQ-020 RTS: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); start timeout counter; go SEND.
REQ-021 SEND: bit counter 0..9; on each device falling edge drive next bit: data[0..7] LSB first, then parity, then stop (ps2_data_oe=0); bit value 1 drives oe=0, value 0 drives oe=1.
REQ-022 SEND to ACK on the 10th falling edge after RTS (stop bit placed).
REQ-023 ACK: on next falling edge sample synchronized data; 0 -> go RELEASE; 1 -> pulse ack_error, go IDLE.
REQ-024 RELEASE: wait until synchronized clk and data both high, then pulse done, go IDLE.
REQ-025 Timeout counter runs in RTS, SEND, ACK, RELEASE; reaching TIMEOUT_CYCLES releases both lines, pulses timeout_error, goes IDLE, overriding any same-cycle edge event.
REQ-026 tx_valid while busy is ignored; tx_data changes after acceptance have no effect.
REQ-027 done, ack_error, timeout_error are mutually exclusive per transfer; exactly one pulses per accepted byte.
REQ-028 All outputs registered; no combinational path from ps2_*_in to outputs.

Reset
REQ-029 On reset low: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=ack_error=timeout_error=0, counters and synchronizers cleared to idle-high levels.
REQ-030 Reset mid-transfer releases both lines immediately (asynchronously); no error pulse is generated.

Configuration
REQ-031 Macro PS2_HOST_TX_RETRY_EN: when defined, first ack_error or timeout of a byte restarts from INHIBIT with the same latched byte without pulsing an error; second failure pulses the error; when undefined, every failure pulses immediately, no retry.

Verification
REQ-032 INHIBIT_CYCLES=20, send 0xED, device model clocks and ACKs -> clk_oe low 20 cycles, bits 1,0,1,1,0,1,1,1, parity 1, stop 1 observed on bus; done pulses once.
REQ-033 Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0; both done.
REQ-034 Device leaves data high at ACK edge for 0xF4 -> ack_error pulse, no done, lines released, tx_ready=1 next cycle.
REQ-035 TIMEOUT_CYCLES=500, device never clocks -> timeout_error exactly 500 cycles after RTS, both oe=0.
REQ-036 Reset low after 4th data bit -> both oe=0 in same cycle, no pulses; fresh 0xED afterward completes with done.
REQ-037 With PS2_HOST_TX_RETRY_EN, first ACK bad, second good -> two INHIBIT phases, single done, no ack_error.
